// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: walks the select lines of an external 8:1 multiplexer,
// holding its active-low enable for a settle time before sampling each
// input, and publishes the assembled 8-bit word with its parity.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; sel=0, mux disabled
// SETUP  | one cycle with mux disabled while sel is stable
// SETTLE | mux enabled, wait counter runs down to zero
// SAMPLE | mux enabled, capture mux_y into shadow[sel], advance sel
// DONE   | mux disabled, shadow word copied to data/parity
module mux8_scan_ctrl #(
    parameter int SETTLE = 2,
    parameter bit INVERT = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       cont,
    input  logic       mux_y,
    output logic [2:0] sel,
    output logic       strobe_n,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       parity
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [2:0] sel_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] shadow, shadow_nx;
    logic [7:0] data_nx;
    logic       parity_nx;
    logic       valid_nx;

    // Register all controller state; reset overrides everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            sel    <= 3'd0;
            cnt    <= 4'd0;
            shadow <= 8'h00;
            data   <= 8'h00;
            parity <= 1'b0;
            valid  <= 1'b0;
        end else begin
            state  <= state_nx;
            sel    <= sel_nx;
            cnt    <= cnt_nx;
            shadow <= shadow_nx;
            data   <= data_nx;
            parity <= parity_nx;
            valid  <= valid_nx;
        end
    end

    // Next-state, select sequencing, capture and publish logic.
    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        cnt_nx    = cnt;
        shadow_nx = shadow;
        data_nx   = data;
        parity_nx = parity;
        valid_nx  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx  = ST_SETUP;
                    sel_nx    = 3'd0;
                    shadow_nx = 8'h00;
                end
            end
            ST_SETUP: begin
                state_nx = ST_SETTLE;
                cnt_nx   = CNT_LOAD;
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nx = ST_SAMPLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_SAMPLE: begin
                shadow_nx[sel] = mux_y ^ INVERT;
                if (sel == 3'd7) begin
                    state_nx = ST_DONE;
                end else begin
                    sel_nx   = sel + 3'd1;
                    state_nx = ST_SETUP;
                end
            end
            ST_DONE: begin
                data_nx   = shadow;
                parity_nx = ^shadow;
                valid_nx  = 1'b1;
                sel_nx    = 3'd0;
                if (cont) begin
                    state_nx  = ST_SETUP;
                    shadow_nx = 8'h00;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                sel_nx   = 3'd0;
            end
        endcase

        // Abort only redirects the sequence; a publish already under way in
        // DONE is left to complete so the word and its valid pulse survive.
        if (abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
            sel_nx   = 3'd0;
        end
    end

    assign strobe_n = !((state == ST_SETTLE) || (state == ST_SAMPLE));
    assign busy     = (state != ST_IDLE);

endmodule
